// File: rtl/ctrl_unit_fsm_if.sv
// Bundle of instruction, flag, interrupt and datapath-strobe signals between
// the control unit and the rest of the CPU.
interface ctrl_unit_fsm_if;
    logic [17:0] prog_ir;
    logic        z;
    logic        c;
    logic        int_req;

    logic        pc_rst;
    logic        pc_inc;
    logic        pc_ld;
    logic [1:0]  pc_mux_sel;
    logic        sp_incr;
    logic        sp_decr;
    logic        scr_we;
    logic        rf_wr;
    logic        flg_z_ld;
    logic        flg_c_ld;
    logic        i_flag;
    logic        illegal;
    logic [1:0]  state;

    // Datapath side: supplies instruction/flags/interrupt, consumes strobes.
    modport master (
        output prog_ir, z, c, int_req,
        input  pc_rst, pc_inc, pc_ld, pc_mux_sel, sp_incr, sp_decr, scr_we,
               rf_wr, flg_z_ld, flg_c_ld, i_flag, illegal, state
    );

    // Control unit side.
    modport slave (
        input  prog_ir, z, c, int_req,
        output pc_rst, pc_inc, pc_ld, pc_mux_sel, sp_incr, sp_decr, scr_we,
               rf_wr, flg_z_ld, flg_c_ld, i_flag, illegal, state
    );
endinterface

// File: rtl/ctrl_unit_fsm.sv
// Four-state CPU control unit: INIT/FETCH/EXEC/INTR sequencing, instruction
// decode into datapath strobes, and the interrupt-enable flag.
module ctrl_unit_fsm #(
    parameter int unsigned INT_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_unit_fsm_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_INTR  = 2'b11
    } state_t;

    typedef enum logic [4:0] {
        OP_NOP   = 5'b00000,
        OP_ALU   = 5'b00001,
        OP_BRN   = 5'b00010,
        OP_BREQ  = 5'b00011,
        OP_BRNE  = 5'b00100,
        OP_BRCS  = 5'b00101,
        OP_CALL  = 5'b00110,
        OP_RET   = 5'b00111,
        OP_SEI   = 5'b01000,
        OP_CLI   = 5'b01001,
        OP_RETIE = 5'b01010
    } op_t;

    localparam logic [1:0] MUX_IMMED  = 2'b00;
    localparam logic [1:0] MUX_STACK  = 2'b01;
    localparam logic [1:0] MUX_VECTOR = 2'b10;

    localparam logic INT_PATH_ON = (INT_EN != 0);

    state_t     state_q;
    state_t     state_d;
    logic       i_flag_q;
    logic       i_flag_d;
    logic [4:0] op;
    logic       take_int;

    logic       pc_rst;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_mux_sel;
    logic       sp_incr;
    logic       sp_decr;
    logic       scr_we;
    logic       rf_wr;
    logic       flg_z_ld;
    logic       flg_c_ld;
    logic       illegal;

    assign op = bus.prog_ir[17:13];

    // Decision uses the flag as held at the start of EXEC, so SEI/CLI in the
    // same instruction only influence later decisions.
    assign take_int = INT_PATH_ON && bus.int_req && i_flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            i_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_flag_q <= i_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_flag_d   = i_flag_q;
        pc_rst     = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        pc_mux_sel = MUX_IMMED;
        sp_incr    = 1'b0;
        sp_decr    = 1'b0;
        scr_we     = 1'b0;
        rf_wr      = 1'b0;
        flg_z_ld   = 1'b0;
        flg_c_ld   = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                pc_rst  = 1'b1;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                pc_inc  = 1'b1;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = take_int ? ST_INTR : ST_FETCH;

                case (op)
                    OP_NOP: ;
                    OP_ALU: begin
                        rf_wr    = 1'b1;
                        flg_z_ld = 1'b1;
                        flg_c_ld = 1'b1;
                    end
                    OP_BRN:  pc_ld = 1'b1;
                    OP_BREQ: pc_ld = bus.z;
                    OP_BRNE: pc_ld = ~bus.z;
                    OP_BRCS: pc_ld = bus.c;
                    OP_CALL: begin
                        pc_ld   = 1'b1;
                        scr_we  = 1'b1;
                        sp_decr = 1'b1;
                    end
                    OP_RET: begin
                        pc_ld      = 1'b1;
                        pc_mux_sel = MUX_STACK;
                        sp_incr    = 1'b1;
                    end
                    OP_SEI: i_flag_d = 1'b1;
                    OP_CLI: i_flag_d = 1'b0;
                    OP_RETIE: begin
                        pc_ld      = 1'b1;
                        pc_mux_sel = MUX_STACK;
                        sp_incr    = 1'b1;
                        i_flag_d   = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end

            ST_INTR: begin
                pc_ld      = 1'b1;
                pc_mux_sel = MUX_VECTOR;
                scr_we     = 1'b1;
                sp_decr    = 1'b1;
                i_flag_d   = 1'b0;
                state_d    = ST_FETCH;
            end

            default: state_d = ST_INIT;
        endcase
    end

    assign bus.pc_rst     = pc_rst;
    assign bus.pc_inc     = pc_inc;
    assign bus.pc_ld      = pc_ld;
    assign bus.pc_mux_sel = pc_mux_sel;
    assign bus.sp_incr    = sp_incr;
    assign bus.sp_decr    = sp_decr;
    assign bus.scr_we     = scr_we;
    assign bus.rf_wr      = rf_wr;
    assign bus.flg_z_ld   = flg_z_ld;
    assign bus.flg_c_ld   = flg_c_ld;
    assign bus.illegal    = illegal;
    assign bus.i_flag     = i_flag_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_ctrl_unit_fsm.sv
// Directed bench for ctrl_unit_fsm: a cycle-by-cycle vector table on the
// interrupt-enabled instance, plus a hand sequence on an INT_EN=0 instance.
module tb_ctrl_unit_fsm;

    logic clk;
    logic rst_a;
    logic rst_b;

    ctrl_unit_fsm_if bus_a ();
    ctrl_unit_fsm_if bus_b ();

    ctrl_unit_fsm #(.INT_EN(1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
    ctrl_unit_fsm #(.INT_EN(0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [4:0] NOP = 5'b00000, ALU = 5'b00001, BRN = 5'b00010,
                           BREQ = 5'b00011, BRNE = 5'b00100, BRCS = 5'b00101,
                           CALL = 5'b00110, RET = 5'b00111, SEI = 5'b01000,
                           CLI = 5'b01001, RETIE = 5'b01010, BAD0 = 5'b01011,
                           BADF = 5'b11111;

    localparam logic [1:0] S_I = 2'b00, S_F = 2'b01, S_E = 2'b10, S_X = 2'b11;

    // Output bits: pc_rst pc_inc pc_ld mux[1:0] sp_incr sp_decr scr_we rf_wr flg_z flg_c illegal
    localparam logic [11:0] O_NONE = 12'h000;
    localparam logic [11:0] O_RST  = 12'h800;
    localparam logic [11:0] O_INC  = 12'h400;
    localparam logic [11:0] O_LD   = 12'h200;
    localparam logic [11:0] O_ALU  = 12'h00E;
    localparam logic [11:0] O_CALL = 12'h230;
    localparam logic [11:0] O_RET  = 12'h2C0;
    localparam logic [11:0] O_VEC  = 12'h330;
    localparam logic [11:0] O_ILL  = 12'h001;

    typedef struct {
        logic        rst;
        logic [4:0]  op;
        logic        z;
        logic        c;
        logic        intr;
        logic [1:0]  st;
        logic        flg;
        logic [11:0] outs;
    } vec_t;

    vec_t tab[$];
    int   checks;
    int   errors;

    function automatic vec_t mkv(logic r, logic [4:0] op, logic z, logic c, logic i,
                                 logic [1:0] st, logic flg, logic [11:0] outs);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.c = c; v.intr = i;
        v.st = st; v.flg = flg; v.outs = outs;
        return v;
    endfunction

    function automatic logic [14:0] snap(bit alt);
        if (alt)
            return {bus_b.state, bus_b.i_flag, bus_b.pc_rst, bus_b.pc_inc, bus_b.pc_ld,
                    bus_b.pc_mux_sel, bus_b.sp_incr, bus_b.sp_decr, bus_b.scr_we,
                    bus_b.rf_wr, bus_b.flg_z_ld, bus_b.flg_c_ld, bus_b.illegal};
        return {bus_a.state, bus_a.i_flag, bus_a.pc_rst, bus_a.pc_inc, bus_a.pc_ld,
                bus_a.pc_mux_sel, bus_a.sp_incr, bus_a.sp_decr, bus_a.scr_we,
                bus_a.rf_wr, bus_a.flg_z_ld, bus_a.flg_c_ld, bus_a.illegal};
    endfunction

    task automatic apply_stimulus(input vec_t v, input bit alt);
        @(negedge clk);
        if (alt) begin
            rst_b = v.rst; bus_b.prog_ir = {v.op, 13'h0A5};
            bus_b.z = v.z; bus_b.c = v.c; bus_b.int_req = v.intr;
        end else begin
            rst_a = v.rst; bus_a.prog_ir = {v.op, 13'h0A5};
            bus_a.z = v.z; bus_a.c = v.c; bus_a.int_req = v.intr;
        end
    endtask

    task automatic check_output(input vec_t v, input bit alt, input string name);
        logic [14:0] act;
        logic [14:0] exp;
        #1;
        act = snap(alt);
        exp = {v.st, v.flg, v.outs};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got state/iflag/outs %b_%b_%b, want %b_%b_%b",
                     name, act[14:13], act[12], act[11:0], exp[14:13], exp[12], exp[11:0]);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        logic [1:0] m_st;
        logic       m_flg;
        int         exec_n;

        checks = 0;
        errors = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.prog_ir = '0; bus_a.z = 1'b0; bus_a.c = 1'b0; bus_a.int_req = 1'b0;
        bus_b.prog_ir = '0; bus_b.z = 1'b0; bus_b.c = 1'b0; bus_b.int_req = 1'b0;

        //                rst op     z  c  int  state flg outputs
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_I, 0, O_RST));
        tab.push_back(mkv(0, BADF,  1, 1, 1,   S_F, 0, O_INC));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_E, 0, O_NONE));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, ALU,   0, 0, 0,   S_E, 0, O_ALU));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, BREQ,  1, 0, 0,   S_E, 0, O_LD));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, BREQ,  0, 1, 0,   S_E, 0, O_NONE));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, BRNE,  0, 0, 0,   S_E, 0, O_LD));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, BRNE,  1, 1, 0,   S_E, 0, O_NONE));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, BRCS,  0, 1, 0,   S_E, 0, O_LD));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, BRCS,  1, 0, 0,   S_E, 0, O_NONE));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, BRN,   0, 0, 0,   S_E, 0, O_LD));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, CALL,  0, 0, 0,   S_E, 0, O_CALL));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, RET,   0, 0, 0,   S_E, 0, O_RET));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, BADF,  1, 1, 0,   S_E, 0, O_ILL));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, BAD0,  0, 0, 0,   S_E, 0, O_ILL));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        // Interrupt raised during the SEI itself must not be taken.
        tab.push_back(mkv(0, SEI,   0, 0, 1,   S_E, 0, O_NONE));
        tab.push_back(mkv(0, NOP,   0, 0, 1,   S_F, 1, O_INC));
        tab.push_back(mkv(0, ALU,   0, 0, 1,   S_E, 1, O_ALU));
        tab.push_back(mkv(0, NOP,   0, 0, 1,   S_X, 1, O_VEC));
        tab.push_back(mkv(0, NOP,   0, 0, 1,   S_F, 0, O_INC));
        tab.push_back(mkv(0, NOP,   0, 0, 1,   S_E, 0, O_NONE));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, SEI,   0, 0, 0,   S_E, 0, O_NONE));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 1, O_INC));
        // CLI with a pending interrupt: decision still sees the old flag.
        tab.push_back(mkv(0, CLI,   0, 0, 1,   S_E, 1, O_NONE));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_X, 0, O_VEC));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, RETIE, 0, 0, 0,   S_E, 0, O_RET));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 1, O_INC));
        tab.push_back(mkv(1, ALU,   0, 0, 1,   S_E, 1, O_ALU));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_I, 0, O_RST));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));
        tab.push_back(mkv(0, SEI,   0, 0, 0,   S_E, 0, O_NONE));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 1, O_INC));
        tab.push_back(mkv(0, NOP,   0, 0, 1,   S_E, 1, O_NONE));
        tab.push_back(mkv(1, NOP,   0, 0, 1,   S_X, 1, O_VEC));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_I, 0, O_RST));
        tab.push_back(mkv(0, NOP,   0, 0, 0,   S_F, 0, O_INC));

        repeat (2) @(posedge clk);

        for (int i = 0; i < tab.size(); i++) begin
            apply_stimulus(tab[i], 1'b0);
            check_output(tab[i], 1'b0, $sformatf("vec%0d", i));
        end

        // INT_EN=0 instance: SEI then a permanently asserted interrupt.
        m_st   = S_I;
        m_flg  = 1'b0;
        exec_n = 0;
        for (int k = 0; k < 12; k++) begin
            v = mkv(0, NOP, 1, 1, 1, m_st, m_flg, O_NONE);
            if (m_st == S_I) v.outs = O_RST;
            else if (m_st == S_F) v.outs = O_INC;
            else if (exec_n == 0) v.op = SEI;
            else if (exec_n == 1) begin
                v.op = BADF;
                v.outs = O_ILL;
            end
            apply_stimulus(v, 1'b1);
            check_output(v, 1'b1, $sformatf("noint_cyc%0d", k));
            if (m_st == S_E) begin
                if (v.op == SEI) m_flg = 1'b1;
                exec_n++;
                m_st = S_F;
            end else begin
                m_st = (m_st == S_I) ? S_F : S_E;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
